mux_8_1_scanner: RTL and testbench
==================================

# mux_8_1_scanner

Sequencing front/back end for the combinational 8:1 mux cell: drives the mux select lines S2..S0 through channels 0..7, waits a programmable settle time on each channel, samples the mux output, and assembles the eight samples into one byte delivered over a valid/ready handshake. Sits around the mux: its select outputs feed the mux select inputs, and the mux output feeds its sample input.

## Interface
- SETTLE_CYCLES, default 2: cycles the select is held before sampling; legal range 1..255.
- CNT_W, default 8: settle counter width; must hold SETTLE_CYCLES.

- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request one 8-channel scan; sampled only in IDLE, or in DONE on the handshake edge.
- abort  input  1  synchronous cancel; highest priority after reset.
- mux_out  input  1  mux output being sampled.
- S0, S1, S2  output  1 each  mux select, channel = {S2,S1,S0}.
- busy  output  1  high in SETTLE/SAMPLE.
- data_out  output  8  assembled word; bit i = sample of channel i.
- data_valid  output  1  word available.
- data_ready  input  1  consumer accepts word.

## Operation
- Reset (rst_n low, asynchronous): state IDLE; S2..S0=0, busy=0, data_valid=0, data_out=8'h00, shadow register=0, counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: select=0. start=1 -> SETTLE, channel=0, shadow cleared, counter=0, busy=1.
- SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE -> SAMPLE.
- SAMPLE (one cycle): on exit edge shadow[channel] <= mux_out. Channel<7 -> channel+1, counter=0, SETTLE. Channel=7 -> data_out <= {mux_out, shadow[6:0]}, data_valid=1, busy=0, select=0, DONE.
- DONE: data_out and data_valid held stable until data_valid&&data_ready at an edge. On that edge: data_valid=0; start=1 in same cycle -> SETTLE (back-to-back, channel 0, shadow cleared); else IDLE.
- start in SETTLE/SAMPLE, or in DONE without data_ready, is ignored (not queued).
- abort=1 in SETTLE/SAMPLE: next edge -> IDLE, select=0, busy=0, partial shadow discarded, data_out unchanged, no data_valid. abort in DONE: drops data_valid, -> IDLE, word lost. abort in IDLE: no effect. abort wins over start in the same cycle.
- data_out only changes on scan completion, never mid-scan.

## Timing
- Select changes only on clock edges; mux_out must be stable by the SAMPLE exit edge.
- Per channel: SETTLE_CYCLES + 1 cycles. Edge E0 accepts start; channel i captured at edge E0 + (i+1)(SETTLE_CYCLES+1).
- data_valid rises at edge E0 + 8(SETTLE_CYCLES+1) (default: E0+24), same edge as channel 7 capture.
- Handshake-to-new-scan: zero bubble with back-to-back start; one IDLE cycle otherwise.
- Counter never wraps: reset to 0 on every channel advance; width CNT_W.

## Structure
- Shared package/include mux_scan_pkg: state encodings (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3), NUM_CH=8, SEL_W=3.
- One sub-module natural: mux_scan_settle_cnt (clear, enable, terminal-count output at SETTLE_CYCLES). FSM, channel register, shadow and output registers in the top.
- Bench instantiates mux_8_1 between S2..S0/mux_out and stimulus D0..D7.

## Test plan
- D7..D0=8'hA5, SETTLE_CYCLES=2, start pulse at E0, data_ready=1 -> selects step 0..7 every 3 cycles, data_valid at E0+24, data_out=8'hA5, returns to IDLE.
- Backpressure: data_ready low 5 cycles after data_valid -> data_valid and data_out=8'hA5 held; accepted on first ready edge; a start during the stall is ignored.
- Back-to-back: start=1 with handshake, D changed to 8'h3C -> no IDLE cycle, second word 8'h3C at handshake edge + 24.
- abort at E0+10 -> IDLE at E0+11, select=0, no data_valid, data_out keeps prior value; later scan of 8'hFF completes normally.
- rst_n low at E0+13 (asynchronous, mid-cycle) -> all outputs 0 immediately; after release, start -> correct word 8'h81.
- SETTLE_CYCLES=1 build -> channel i captured at E0+2(i+1), data_valid at E0+16; start during busy has no effect.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: state encodings and channel geometry shared by the 8:1 mux scanner files.
package mux_scan_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
endpackage

// File: rtl/mux_scan_settle_cnt.sv
// mux_scan_settle_cnt: settle-time counter; o_tc marks the last cycle of the settle window.
// Ports: clk, rst_n (async active-low), i_clr (sync clear, wins over i_en),
//        i_en (count this cycle), o_tc (high on the SETTLE_CYCLES-th enabled cycle).
module mux_scan_settle_cnt #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CNT_W'(1);
  end
  // r_cnt counts completed settle cycles, so SETTLE_CYCLES-1 means this is the final one
  assign o_tc = i_en && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/mux_8_1_scanner.sv
// mux_8_1_scanner: steps an 8:1 mux through all channels, samples each and returns one byte.
// Ports: clk, rst_n (async active-low), start (begin scan), abort (cancel),
//        mux_out (sampled mux output), S2..S0 (mux select), busy (scan in progress),
//        data_out/data_valid/data_ready (assembled word with valid/ready handshake).
module mux_8_1_scanner
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready
);
  state_t             r_state;
  logic [SEL_W-1:0]   r_ch;
  logic [NUM_CH-1:0]  r_shadow;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_busy;
  logic               w_tc;
  logic               w_in_settle;
  assign w_in_settle = (r_state == SETTLE);
  mux_scan_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(!w_in_settle),
    .i_en (w_in_settle),
    .o_tc (w_tc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (abort) begin
      // partial samples are dropped and data_out keeps the last completed word
      r_state  <= IDLE;
      r_ch     <= '0;
      r_shadow <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state  <= SETTLE;
          r_ch     <= '0;
          r_shadow <= '0;
          r_busy   <= 1'b1;
        end
        SETTLE: if (w_tc) r_state <= SAMPLE;
        SAMPLE: begin
          r_shadow[r_ch] <= mux_out;
          if (r_ch == SEL_W'(NUM_CH - 1)) begin
            // channel 7 goes straight into the word; shadow only holds 0..6 here
            r_data  <= {mux_out, r_shadow[NUM_CH-2:0]};
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_ch    <= '0;
            r_state <= DONE;
          end else begin
            r_ch    <= r_ch + SEL_W'(1);
            r_state <= SETTLE;
          end
        end
        DONE: if (data_ready) begin
          r_valid  <= 1'b0;
          r_busy   <= start;
          r_ch     <= '0;
          r_shadow <= '0;
          r_state  <= start ? SETTLE : IDLE;
        end
      endcase
    end
  end
  assign {S2, S1, S0} = r_ch;
  assign busy         = r_busy;
  assign data_out     = r_data;
  assign data_valid   = r_valid;
endmodule

// File: tb/tb_mux_8_1_scanner.sv
// tb_mux_8_1_scanner: scoreboard bench for the scanner with a behavioural 8:1 mux in the loop.
module tb_mux_8_1_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, data_ready = 1'b0;
  logic [7:0] d = 8'h00;
  logic       mux_out, S0, S1, S2, busy, data_valid;
  logic [7:0] data_out;
  logic       start1 = 1'b0, data_ready1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       mux_out1, S0_1, S1_1, S2_1, busy1, data_valid1;
  logic [7:0] data_out1;
  logic [2:0] sel, sel1;
  logic [7:0] q[$];
  logic [7:0] q1[$];
  logic [7:0] last = 8'h00;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign sel      = {S2, S1, S0};
  assign sel1     = {S2_1, S1_1, S0_1};
  assign mux_out  = d[sel];
  assign mux_out1 = d1[sel1];

  mux_8_1_scanner u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mux_out(mux_out),
    .S0(S0), .S1(S1), .S2(S2), .busy(busy), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready)
  );

  mux_8_1_scanner #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .mux_out(mux_out1),
    .S0(S0_1), .S1(S1_1), .S2(S2_1), .busy(busy1), .data_out(data_out1),
    .data_valid(data_valid1), .data_ready(data_ready1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_word(input int lat, input string nm);
    int n = 0;
    logic [7:0] exp;
    while (!data_valid && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != lat) begin n_err++; $display("FAIL %s_latency got=%0d exp=%0d", nm, n, lat); end
    n_cmp++;
    if (q.size() == 0) begin
      n_err++; $display("FAIL %s_word got=%h exp=<none queued>", nm, data_out);
    end else begin
      exp = q.pop_front();
      last = exp;
      if (data_out !== exp) begin n_err++; $display("FAIL %s_word got=%h exp=%h", nm, data_out, exp); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({sel, busy, data_valid} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl got=%b exp=00000", {sel, busy, data_valid}); end
    n_cmp++;
    if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data_out); end
    n_cmp++;
    if ({sel1, busy1, data_valid1, data_out1} !== 13'b0) begin n_err++; $display("FAIL reset_dut1 got=%b exp=0", {sel1, busy1, data_valid1, data_out1}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] w;
    logic [7:0] exp;
    w = 8'hA5;
    data_ready = 1'b1;
    q.push_back(w);
    d = ~w;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n <= 24; n++) begin
      if (n > 0) tick();
      // the true word is only presented in the cycle before each capture edge
      d = ((n + 1) % 3 == 0) ? w : ~w;
      n_cmp++;
      if (sel !== (n < 24 ? 3'(n / 3) : 3'd0)) begin n_err++; $display("FAIL basic_sel n=%0d got=%0d exp=%0d", n, sel, n < 24 ? n / 3 : 0); end
      n_cmp++;
      if (data_valid !== (n == 24)) begin n_err++; $display("FAIL basic_valid n=%0d got=%b exp=%b", n, data_valid, n == 24); end
      n_cmp++;
      if (busy !== (n < 24)) begin n_err++; $display("FAIL basic_busy n=%0d got=%b exp=%b", n, busy, n < 24); end
    end
    exp = q.pop_front();
    last = exp;
    n_cmp++;
    if (data_out !== exp) begin n_err++; $display("FAIL basic_word got=%h exp=%h", data_out, exp); end
    tick();
    n_cmp++;
    if ({data_valid, busy} !== 2'b00) begin n_err++; $display("FAIL basic_idle got=%b exp=00", {data_valid, busy}); end
    tick();
  endtask

  task automatic test_backpressure();
    data_ready = 1'b0;
    d = 8'hA5;
    q.push_back(8'hA5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_word(24, "bp");
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      tick();
      n_cmp++;
      if ({data_valid, data_out} !== {1'b1, last}) begin n_err++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/%h", k, data_valid, data_out, last); end
    end
    start = 1'b0;
    data_ready = 1'b1;
    tick();
    n_cmp++;
    if ({data_valid, busy} !== 2'b00) begin n_err++; $display("FAIL bp_accept got=%b exp=00", {data_valid, busy}); end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL bp_start_ignored got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    data_ready = 1'b0;
    d = 8'h5A;
    q.push_back(8'h5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_word(24, "b2b_first");
    d = 8'h3C;
    q.push_back(8'h3C);
    data_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({data_valid, busy, sel} !== 5'b01000) begin n_err++; $display("FAIL b2b_restart got=%b exp=01000", {data_valid, busy, sel}); end
    wait_word(24, "b2b_second");
    tick();
    n_cmp++;
    if (data_valid !== 1'b0) begin n_err++; $display("FAIL b2b_accept got=%b exp=0", data_valid); end
  endtask

  task automatic test_abort();
    int seen = 0;
    data_ready = 1'b1;
    d = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if (sel !== 3'd3) begin n_err++; $display("FAIL abort_presel got=%0d exp=3", sel); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({busy, data_valid, sel} !== 5'b0) begin n_err++; $display("FAIL abort_idle got=%b exp=00000", {busy, data_valid, sel}); end
    n_cmp++;
    if (data_out !== last) begin n_err++; $display("FAIL abort_data got=%h exp=%h", data_out, last); end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (data_valid || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
    d = 8'hFF;
    q.push_back(8'hFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_word(24, "abort_rescan");
    tick();
    data_ready = 1'b0;
    d = 8'h11;
    q.push_back(8'h11);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_word(24, "abort_done_scan");
    abort = 1'b1;
    start = 1'b1;
    data_ready = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    n_cmp++;
    if ({busy, data_valid} !== 2'b00) begin n_err++; $display("FAIL abort_done got=%b exp=00", {busy, data_valid}); end
    tick();
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b1;
    d = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel, busy, data_valid, data_out} !== 13'b0) begin n_err++; $display("FAIL midreset_outs got=%b exp=0", {sel, busy, data_valid, data_out}); end
    #3;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_idle got=%b exp=0", busy); end
    d = 8'h81;
    q.push_back(8'h81);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_word(24, "midreset_scan");
    tick();
  endtask

  task automatic test_settle1();
    logic [7:0] w;
    logic [7:0] exp;
    w = 8'h96;
    data_ready1 = 1'b1;
    q1.push_back(w);
    d1 = ~w;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) tick();
      start1 = (n == 4);
      d1 = ((n + 1) % 2 == 0) ? w : ~w;
      n_cmp++;
      if (sel1 !== (n < 16 ? 3'(n / 2) : 3'd0)) begin n_err++; $display("FAIL s1_sel n=%0d got=%0d exp=%0d", n, sel1, n < 16 ? n / 2 : 0); end
      n_cmp++;
      if (data_valid1 !== (n == 16)) begin n_err++; $display("FAIL s1_valid n=%0d got=%b exp=%b", n, data_valid1, n == 16); end
    end
    start1 = 1'b0;
    exp = q1.pop_front();
    n_cmp++;
    if (data_out1 !== exp) begin n_err++; $display("FAIL s1_word got=%h exp=%h", data_out1, exp); end
    tick();
    n_cmp++;
    if ({data_valid1, busy1} !== 2'b00) begin n_err++; $display("FAIL s1_idle got=%b exp=00", {data_valid1, busy1}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_settle1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
